// File: rtl/gf180mcu_fd_sc_mcu9t5v0__dlycal_ctrl.sv
// Delay-line calibration sequencer: sweeps tap select upward and reports the first tap that misses the capture window.
// Optional majority vote over three launches per tap is enabled by defining DLYCAL_VOTE_EN.
module gf180mcu_fd_sc_mcu9t5v0__dlycal_ctrl #(
  parameter int NTAPS  = 16,
  parameter int TAPW   = 4,
  parameter int SETTLE = 4,
  parameter int CNTW   = 3
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            START,
  input  logic            SAMPLE,
  output logic            LAUNCH_O,
  output logic [TAPW-1:0] TAP_SEL,
  output logic            BUSY,
  output logic            DONE,
  output logic [TAPW-1:0] RESULT,
  output logic            ERR,
  output logic [2:0]      DBG_STATE
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_EVAL    = 3'd3,
    S_RECOVER = 3'd4,
    S_FIN     = 3'd5
  } state_t;

  localparam logic [CNTW-1:0] SETTLE_C = CNTW'(SETTLE);
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [TAPW-1:0] LAST_TAP = TAPW'(NTAPS - 1);

  state_t          state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [TAPW-1:0] tap_q, tap_d;
  logic [TAPW-1:0] result_q, result_d;
  logic            launch_q, launch_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // eval_final: this EVAL decides the tap; eval_hit: the decided outcome.
  logic            eval_final;
  logic            eval_hit;

`ifdef DLYCAL_VOTE_EN
  logic [1:0]      hit_cnt_q, hit_cnt_d;
  logic [1:0]      round_q, round_d;
  logic [1:0]      hits_sum;

  always_comb begin
    hits_sum   = hit_cnt_q + {1'b0, SAMPLE};
    eval_final = (round_q == 2'd2);
    eval_hit   = (hits_sum >= 2'd2);
  end
`else
  always_comb begin
    eval_final = 1'b1;
    eval_hit   = SAMPLE;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tap_d    = tap_q;
    result_d = result_q;
    launch_d = launch_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
`ifdef DLYCAL_VOTE_EN
    hit_cnt_d = hit_cnt_q;
    round_d   = round_q;
`endif
    case (state_q)
      S_IDLE: begin
        launch_d = 1'b0;
        busy_d   = 1'b0;
        if (START) begin
          state_d  = S_LAUNCH;
          tap_d    = '0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          launch_d = 1'b1;
`ifdef DLYCAL_VOTE_EN
          hit_cnt_d = 2'd0;
          round_d   = 2'd0;
`endif
        end
      end
      S_LAUNCH: begin
        cnt_d    = SETTLE_C;
        launch_d = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_EVAL;
        end
      end
      S_EVAL: begin
        if (!eval_final) begin
`ifdef DLYCAL_VOTE_EN
          hit_cnt_d = hits_sum;
          round_d   = round_q + 2'd1;
`endif
          state_d  = S_RECOVER;
          cnt_d    = SETTLE_C;
          launch_d = 1'b0;
        end else if (!eval_hit) begin
          result_d = tap_q;
          state_d  = S_FIN;
          done_d   = 1'b1;
          launch_d = 1'b0;
        end else if (tap_q == LAST_TAP) begin
          result_d = LAST_TAP;
          err_d    = 1'b1;
          state_d  = S_FIN;
          done_d   = 1'b1;
          launch_d = 1'b0;
        end else begin
          tap_d    = tap_q + TAPW'(1);
          state_d  = S_RECOVER;
          cnt_d    = SETTLE_C;
          launch_d = 1'b0;
        end
`ifdef DLYCAL_VOTE_EN
        if (eval_final) begin
          hit_cnt_d = 2'd0;
          round_d   = 2'd0;
        end
`endif
      end
      S_RECOVER: begin
        // Line is held low for SETTLE cycles so the previous edge fully drains.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d  = S_LAUNCH;
          launch_d = 1'b1;
        end
      end
      S_FIN: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        launch_d = 1'b0;
      end
      default: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        launch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tap_q    <= '0;
      result_q <= '0;
      launch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef DLYCAL_VOTE_EN
      hit_cnt_q <= 2'd0;
      round_q   <= 2'd0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tap_q    <= tap_d;
      result_q <= result_d;
      launch_q <= launch_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef DLYCAL_VOTE_EN
      hit_cnt_q <= hit_cnt_d;
      round_q   <= round_d;
`endif
    end
  end

  assign LAUNCH_O  = launch_q;
  assign TAP_SEL   = tap_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign RESULT    = result_q;
  assign ERR       = err_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__dlycal_ctrl.sv
// Directed bench for the delay-line calibration sequencer (SETTLE=4, NTAPS=16).
// Expected cycle numbers count from the START-accept edge (cycle 1 = first cycle after it).
module tb_gf180mcu_fd_sc_mcu9t5v0__dlycal_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       SAMPLE;
  logic       LAUNCH_O;
  logic [3:0] TAP_SEL;
  logic       BUSY;
  logic       DONE;
  logic [3:0] RESULT;
  logic       ERR;
  logic [2:0] DBG_STATE;

  gf180mcu_fd_sc_mcu9t5v0__dlycal_ctrl #(
    .NTAPS(16), .TAPW(4), .SETTLE(4), .CNTW(3)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .SAMPLE(SAMPLE),
    .LAUNCH_O(LAUNCH_O), .TAP_SEL(TAP_SEL), .BUSY(BUSY), .DONE(DONE),
    .RESULT(RESULT), .ERR(ERR), .DBG_STATE(DBG_STATE)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  int done_cyc;
  int busy_bad;
  int low_runs;
  int low_min;
  int low_max;
  int done_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Vote-mode capture pattern indexed by global launch round r (3 rounds per tap).
  function automatic logic vote_pat(input int r);
    int t;
    int s;
    t = r / 3;
    s = r % 3;
    if (t < 2) return 1'b1;
    if (t == 2) return (s != 1);
    if (t == 3) return (s == 1);
    return 1'b0;
  endfunction

  // Starts a sweep and runs until DONE or budget; capture flop hits on launch rounds below miss_tap.
  task automatic sweep(input int miss_tap, input bit hold, input bit vote, input int budget);
    int c;
    int run;
    int launches;
    logic prev;
    done_cyc = -1;
    busy_bad = 0;
    low_runs = 0;
    low_min  = 999;
    low_max  = 0;
    run      = 0;
    launches = 0;
    prev     = 1'b0;
    START    = 1'b1;
    SAMPLE   = 1'b0;
    step();
    if (!hold) START = 1'b0;
    c = 1;
    while (c <= budget) begin
      if (LAUNCH_O && !prev) launches++;
      prev = LAUNCH_O;
      SAMPLE = vote ? vote_pat(launches - 1) : ((launches - 1) < miss_tap);
      if (DONE === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (BUSY !== 1'b1) busy_bad++;
      if (LAUNCH_O === 1'b0) begin
        run++;
      end else if (run > 0) begin
        low_runs++;
        if (run < low_min) low_min = run;
        if (run > low_max) low_max = run;
        run = 0;
      end
      step();
      c++;
    end
  endtask

  initial begin
    RST    = 1'b1;
    START  = 1'b0;
    SAMPLE = 1'b0;
    step();
    step();
    RST = 1'b0;
    chk("rst_launch", LAUNCH_O, 0);
    chk("rst_tap", TAP_SEL, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_done", DONE, 0);
    chk("rst_result", RESULT, 0);
    chk("rst_err", ERR, 0);
    chk("rst_state", DBG_STATE, 0);

    // Reset asserted for two cycles in the middle of WAIT.
    START = 1'b1;
    step();
    START = 1'b0;
    step();
    step();
    chk("t1_in_wait", DBG_STATE, 2);
    chk("t1_launch_hi", LAUNCH_O, 1);
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
    chk("t1_launch", LAUNCH_O, 0);
    chk("t1_busy", BUSY, 0);
    chk("t1_done", DONE, 0);
    chk("t1_state", DBG_STATE, 0);
    chk("t1_tap", TAP_SEL, 0);
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (DONE === 1'b1 || BUSY === 1'b1) done_seen++;
    end
    chk("t1_no_done", done_seen, 0);

`ifdef DLYCAL_VOTE_EN
    // Taps 0,1 always hit; tap 2 votes 1,0,1 (hit); tap 3 votes 0,1,0 (miss).
    sweep(0, 1'b0, 1'b1, 600);
    chk("v_done_cyc", done_cyc, 117);
    chk("v_result", RESULT, 3);
    chk("v_err", ERR, 0);
    chk("v_busy_bad", busy_bad, 0);
    chk("v_low_runs", low_runs, 11);
    chk("v_low_min", low_min, 4);
    chk("v_low_max", low_max, 4);
    chk("v_tap", TAP_SEL, 3);
    step();
    chk("v_idle", BUSY, 0);
    chk("v_done_drop", DONE, 0);
`else
    // Miss on the very first tap.
    sweep(0, 1'b0, 1'b0, 200);
    chk("t2_done_cyc", done_cyc, 7);
    chk("t2_result", RESULT, 0);
    chk("t2_err", ERR, 0);
    chk("t2_busy_bad", busy_bad, 0);
    chk("t2_busy_at_done", BUSY, 1);
    step();
    chk("t2_busy_after", BUSY, 0);
    chk("t2_done_pulse", DONE, 0);
    chk("t2_launch_after", LAUNCH_O, 0);

    // Hits on taps 0..4, miss at tap 5.
    sweep(5, 1'b0, 1'b0, 400);
    chk("t3_done_cyc", done_cyc, 57);
    chk("t3_result", RESULT, 5);
    chk("t3_err", ERR, 0);
    chk("t3_low_runs", low_runs, 5);
    chk("t3_low_min", low_min, 4);
    chk("t3_low_max", low_max, 4);
    chk("t3_tap", TAP_SEL, 5);
    chk("t3_busy_bad", busy_bad, 0);
    step();

    // Never misses: sweep ends on the last tap with ERR.
    sweep(100, 1'b0, 1'b0, 400);
    chk("t4_done_cyc", done_cyc, 157);
    chk("t4_result", RESULT, 15);
    chk("t4_err", ERR, 1);
    chk("t4_tap", TAP_SEL, 15);
    for (int i = 0; i < 5; i++) step();
    chk("t4_tap_hold", TAP_SEL, 15);
    chk("t4_err_hold", ERR, 1);
    chk("t4_result_hold", RESULT, 15);
    chk("t4_idle", BUSY, 0);
    SAMPLE = 1'b0;
    START  = 1'b1;
    step();
    START = 1'b0;
    chk("t4_err_clr", ERR, 0);
    chk("t4_tap_restart", TAP_SEL, 0);
    chk("t4_busy_restart", BUSY, 1);
    chk("t4_result_kept", RESULT, 15);
    for (int i = 0; i < 6; i++) step();
    chk("t4_second_done", DONE, 1);
    chk("t4_second_result", RESULT, 0);
    step();

    // START held high through the sweep and past DONE.
    sweep(2, 1'b1, 1'b0, 300);
    chk("t5_done_cyc", done_cyc, 27);
    chk("t5_result", RESULT, 2);
    step();
    chk("t5_idle_busy", BUSY, 0);
    chk("t5_idle_done", DONE, 0);
    chk("t5_idle_tap", TAP_SEL, 2);
    step();
    START = 1'b0;
    chk("t5_rearm_busy", BUSY, 1);
    chk("t5_rearm_tap", TAP_SEL, 0);
    chk("t5_rearm_launch", LAUNCH_O, 1);
    for (int i = 0; i < 6; i++) step();
    chk("t5_rearm_done", DONE, 1);
    chk("t5_rearm_result", RESULT, 0);
    step();
    chk("t5_final_idle", BUSY, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
